// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and round-robin pick helper for the bus master arbiter
package bus_arb_pkg;

    localparam int MAX_MASTERS = 2;

    typedef logic [$clog2(MAX_MASTERS)-1:0] master_id_t;

    // The lowest offset from ptr that is requesting wins; ptr is returned when nobody requests.
    function automatic master_id_t rr_pick(input logic [MAX_MASTERS-1:0] req, input master_id_t ptr);
        master_id_t pick;
        master_id_t idx;
        pick = ptr;
        for (int i = MAX_MASTERS - 1; i >= 0; i--) begin
            idx = master_id_t'((int'(ptr) + i) % MAX_MASTERS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage

// File: rtl/bus_master_arb_if.sv
// rtl/bus_master_arb_if.sv - requester-side and bus-side signals of the bus master arbiter
interface bus_master_arb_if #(parameter int NUM_MASTERS = 2);

    logic [NUM_MASTERS-1:0]    m_req_i;
    logic [NUM_MASTERS-1:0]    m_we_i;
    logic [NUM_MASTERS*4-1:0]  m_be_i;
    logic [NUM_MASTERS*32-1:0] m_addr_i;
    logic [NUM_MASTERS*32-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]    m_gnt_o;
    logic [NUM_MASTERS-1:0]    m_rvalid_o;
    logic [31:0]               m_rdata_o;
    logic [NUM_MASTERS-1:0]    m_err_o;
    logic                      s_req_o;
    logic                      s_gnt_i;
    logic                      s_we_o;
    logic [3:0]                s_be_o;
    logic [31:0]               s_addr_o;
    logic [31:0]               s_wdata_o;
    logic                      s_rvalid_i;
    logic [31:0]               s_rdata_i;
    logic                      s_err_i;

    // slave: the arbiter itself; master: requesters plus the bus slave around it
    modport slave (
        input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o
    );

endinterface

// File: rtl/bus_arb_id_fifo.sv
// rtl/bus_arb_id_fifo.sv - in-order FIFO of requester IDs for granted-but-unanswered transfers
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  master_id_t    din_i,
    output master_id_t    dout_o,
    output logic [CW-1:0] cnt_o
);

    master_id_t    mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_push = push_i && (cnt_q != CW'(DEPTH));
        do_pop  = pop_i && (cnt_q != '0);
        wr_d    = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d    = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d   = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/bus_master_arb.sv
// rtl/bus_master_arb.sv - round-robin arbiter sharing one bus master port; BUS_ARB_DBG_PRIO_EN gives requester 0 priority
module bus_master_arb
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS     = MAX_MASTERS,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic                clk_i,
    input logic                rst_ni,
    bus_master_arb_if.slave    bus
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    master_id_t    rr_q, rr_d, lock_id_q, lock_id_d, winner, head_id;
    logic          lock_q, lock_d;
    logic [CW-1:0] fifo_cnt;
    logic          any_req, full, empty, s_req, hs, pop;

    bus_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (hs),
        .pop_i  (pop),
        .din_i  (winner),
        .dout_o (head_id),
        .cnt_o  (fifo_cnt)
    );

    always_comb begin
        any_req = |bus.m_req_i;
        full    = (fifo_cnt == CW'(MAX_OUTSTANDING));
        empty   = (fifo_cnt == '0);

        // A waiting request is pinned so the bus never sees its address change before the grant.
        if (lock_q) begin
            winner = lock_id_q;
        end else begin
`ifdef BUS_ARB_DBG_PRIO_EN
            if (bus.m_req_i[0]) winner = '0;
            else                winner = rr_pick(bus.m_req_i & ~NUM_MASTERS'(1), rr_q);
`else
            winner = rr_pick(bus.m_req_i, rr_q);
`endif
        end

        s_req = any_req && !full;
        hs    = s_req && bus.s_gnt_i;
        pop   = bus.s_rvalid_i && !empty;

        bus.s_req_o   = s_req;
        bus.s_we_o    = any_req ? bus.m_we_i[winner] : 1'b0;
        bus.s_be_o    = any_req ? bus.m_be_i[4*winner +: 4] : '0;
        bus.s_addr_o  = any_req ? bus.m_addr_i[32*winner +: 32] : '0;
        bus.s_wdata_o = any_req ? bus.m_wdata_i[32*winner +: 32] : '0;

        bus.m_gnt_o             = '0;
        bus.m_gnt_o[winner]     = hs;
        bus.m_rvalid_o          = '0;
        bus.m_rvalid_o[head_id] = pop;
        bus.m_err_o             = '0;
        bus.m_err_o[head_id]    = pop && bus.s_err_i;
        bus.m_rdata_o           = pop ? bus.s_rdata_i : '0;

        rr_d      = hs ? master_id_t'((int'(winner) + 1) % NUM_MASTERS) : rr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (hs) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q      <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    a_rvalid_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.s_rvalid_i && empty));

    a_locked_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> bus.m_req_i[lock_id_q]);

endmodule

// File: tb/tb_bus_master_arb.sv
// tb/tb_bus_master_arb.sv - scoreboard bench for bus_master_arb
module tb_bus_master_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    bus_master_arb_if #(.NUM_MASTERS(2)) bus ();

    bus_master_arb #(.NUM_MASTERS(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [1:0] req, input logic gnt, input logic rv,
                           input logic [31:0] rd, input logic err);
        bus.m_req_i    = req;
        bus.s_gnt_i    = gnt;
        bus.s_rvalid_i = rv;
        bus.s_rdata_i  = rd;
        bus.s_err_i    = err;
    endtask

    function automatic logic [1:0] oh(input int id);
        logic [1:0] v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic grant_chk(input string tag, input int id);
        chk(tag, bus.m_gnt_o, oh(id));
        exp_q.push_back(id);
    endtask

    task automatic resp_chk(input string tag, input logic [31:0] rd, input logic err);
        int id;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: response with empty scoreboard", tag);
        end else begin
            id = exp_q.pop_front();
            chk({tag, "_rvalid"}, bus.m_rvalid_o, oh(id));
            chk({tag, "_rdata"}, bus.m_rdata_o, rd);
            chk({tag, "_err"}, bus.m_err_o, err ? oh(id) : 2'b00);
        end
    endtask

    localparam logic [31:0] A0 = 32'h2000_0020;
    localparam logic [31:0] A1 = 32'h1000_0010;

    initial begin
        bus.m_we_i    = 2'b01;
        bus.m_be_i    = 8'hF3;
        bus.m_addr_i  = {A1, A0};
        bus.m_wdata_i = {32'hBBBB_0001, 32'hAAAA_0000};
        set_bus(2'b00, 1'b1, 1'b0, 32'h0, 1'b0);

        @(negedge clk);
        chk("rst_s_req", bus.s_req_o, 1'b0);
        chk("rst_gnt", bus.m_gnt_o, 2'b00);
        chk("rst_rvalid", bus.m_rvalid_o, 2'b00);
        chk("rst_addr", bus.s_addr_o, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // single read from requester 1
        bus.m_addr_i[63:32] = 32'h8000_0000;
        set_bus(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t1_s_req", bus.s_req_o, 1'b1);
        chk("t1_addr", bus.s_addr_o, 32'h8000_0000);
        chk("t1_we", bus.s_we_o, 1'b0);
        chk("t1_be", bus.s_be_o, 4'hF);
        grant_chk("t1_gnt", 1);
        tick();
        set_bus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        resp_chk("t1_resp", 32'hDEAD_BEEF, 1'b0);
        tick();
        bus.m_addr_i[63:32] = A1;

        // both requesting continuously, immediate responses
        for (int k = 0; k < 5; k++) begin
            set_bus((k < 4) ? 2'b11 : 2'b00, 1'b1, k > 0, 32'hA000_0000 + k, 1'b0);
            @(negedge clk);
            if (k > 0) resp_chk("t2_resp", 32'hA000_0000 + k, 1'b0);
            if (k < 4) begin
`ifdef BUS_ARB_DBG_PRIO_EN
                grant_chk("t2_gnt", 0);
`else
                grant_chk("t2_gnt", k % 2);
`endif
            end
            tick();
        end

        // bus stalls requester 1; requester 0 must not steal the pending slot
        for (int k = 0; k < 3; k++) begin
            set_bus((k == 2) ? 2'b11 : 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            chk("t3_wait_addr", bus.s_addr_o, A1);
            chk("t3_wait_gnt", bus.m_gnt_o, 2'b00);
            tick();
        end
        set_bus(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t3_addr", bus.s_addr_o, A1);
        grant_chk("t3_gnt1", 1);
        tick();
        set_bus(2'b01, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
        @(negedge clk);
        resp_chk("t3_resp1", 32'h1111_1111, 1'b0);
        chk("t3_addr0", bus.s_addr_o, A0);
        grant_chk("t3_gnt0", 0);
        tick();
        set_bus(2'b00, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
        @(negedge clk);
        resp_chk("t3_resp0", 32'h2222_2222, 1'b0);
        tick();

        // outstanding limit
        set_bus(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        grant_chk("t4_gnt_a", 1);
        tick();
        set_bus(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        grant_chk("t4_gnt_b", 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            set_bus(2'b01, 1'b1, k == 2, 32'h4444_0000, 1'b0);
            @(negedge clk);
            if (k == 2) resp_chk("t4_resp_a", 32'h4444_0000, 1'b0);
            chk("t4_full_s_req", bus.s_req_o, 1'b0);
            chk("t4_full_gnt", bus.m_gnt_o, 2'b00);
            tick();
        end
        set_bus(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t4_unblock_s_req", bus.s_req_o, 1'b1);
        grant_chk("t4_gnt_c", 0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_bus(2'b00, 1'b0, 1'b1, 32'h4444_0001 + k, 1'b0);
            @(negedge clk);
            resp_chk("t4_resp", 32'h4444_0001 + k, 1'b0);
            tick();
        end

        // interleaved errors
        set_bus(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        grant_chk("t5_gnt0", 0);
        tick();
        set_bus(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        grant_chk("t5_gnt1", 1);
        tick();
        set_bus(2'b00, 1'b0, 1'b1, 32'h5555_0000, 1'b1);
        @(negedge clk);
        resp_chk("t5_resp0", 32'h5555_0000, 1'b1);
        tick();
        set_bus(2'b00, 1'b0, 1'b1, 32'h5555_0001, 1'b0);
        @(negedge clk);
        resp_chk("t5_resp1", 32'h5555_0001, 1'b0);
        tick();

        // reset with a transfer outstanding and the lock held
        set_bus(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        set_bus(2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        set_bus(2'b00, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t6_s_req", bus.s_req_o, 1'b0);
        chk("t6_gnt", bus.m_gnt_o, 2'b00);
        chk("t6_addr", bus.s_addr_o, 32'h0);
        chk("t6_rdata", bus.m_rdata_o, 32'h0);
        tick();
        rst_n = 1'b1;
        set_bus(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t6_addr_after", bus.s_addr_o, A0);
        grant_chk("t6_gnt_a", 0);
        tick();
        @(negedge clk);
        chk("t6_s_req_after", bus.s_req_o, 1'b1);
`ifdef BUS_ARB_DBG_PRIO_EN
        grant_chk("t6_gnt_b", 0);
`else
        grant_chk("t6_gnt_b", 1);
`endif
        tick();
        for (int k = 0; k < 2; k++) begin
            set_bus(2'b00, 1'b0, 1'b1, 32'h6666_0000 + k, 1'b0);
            @(negedge clk);
            resp_chk("t6_resp", 32'h6666_0000 + k, 1'b0);
            tick();
        end
        set_bus(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
